// File: rtl/uart_rx_param_pkg.sv
// Shared definitions for the parametrised UART receiver: state encoding,
// parity-mode constants and a width helper.
package uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    START  = ST_START,
    DATA   = ST_DATA,
    PARITY = ST_PARITY,
    STOP   = ST_STOP
  } state_t;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  // Bits needed to count 0..value-1, never less than one.
  function automatic int clog2_min1(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/uart_rx_param_if.sv
// Host-side signal bundle of the UART receiver; master drives the line and
// tick, slave is the receiver.
interface uart_rx_param_if #(
  parameter int DBIT = 8
);
  logic            rx;
  logic            s_tick;
  logic [1:0]      parity_mode;
  logic            rx_done_tick;
  logic [DBIT-1:0] dout;
  logic            parity_err;
  logic            frame_err;
  logic            rx_busy;

  modport master (
    output rx, s_tick, parity_mode,
    input  rx_done_tick, dout, parity_err, frame_err, rx_busy
  );

  modport slave (
    input  rx, s_tick, parity_mode,
    output rx_done_tick, dout, parity_err, frame_err, rx_busy
  );
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous serial line; resets to 1 so an
// idle line is never mistaken for a start bit.
module uart_rx_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic i_d,
  output logic o_q
);
  logic [1:0] r_sync;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_sync <= 2'b11;
    else          r_sync <= {r_sync[0], i_d};
  end

  assign o_q = r_sync[1];
endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with run-time parity mode, false-start rejection
// and framing check. Define UART_RX_MAJORITY_EN for 2-of-3 bit voting.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int OVS     = 16,
  parameter int SB_TICK = 16
) (
  input logic           clk,
  input logic           reset_n,
  uart_rx_param_if.slave bus
);
  localparam int SMAX = (OVS > SB_TICK) ? OVS : SB_TICK;
  localparam int SW   = clog2_min1(SMAX);
  localparam int NW   = clog2_min1(DBIT);

  localparam logic [SW-1:0] S_HALF = SW'(OVS / 2 - 1);
  localparam logic [SW-1:0] S_BIT  = SW'(OVS - 1);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [SW-1:0] S_ONE  = SW'(1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);
  localparam logic [NW-1:0] N_ONE  = NW'(1);

  state_t          r_state, w_state;
  logic [SW-1:0]   r_s, w_s;
  logic [NW-1:0]   r_n, w_n;
  logic [DBIT-1:0] r_b, w_b;
  logic            r_par, w_par;
  logic            r_perr, w_perr;
  logic [1:0]      r_pm, w_pm;
  logic [DBIT-1:0] r_dout, w_dout;
  logic            r_done, w_done;
  logic            r_perr_o, w_perr_o;
  logic            r_ferr, w_ferr;
  logic            w_rx_s;
  logic            w_bit;
  logic            w_par_en;

  uart_rx_sync u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .i_d     (bus.rx),
    .o_q     (w_rx_s)
  );

`ifdef UART_RX_MAJORITY_EN
  // The two previous tick samples plus the current one vote on the bit value.
  logic [1:0] r_hist;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        r_hist <= 2'b11;
    else if (bus.s_tick) r_hist <= {r_hist[0], w_rx_s};
  end

  assign w_bit = (r_hist[0] & r_hist[1]) | (r_hist[0] & w_rx_s) | (r_hist[1] & w_rx_s);
`else
  assign w_bit = w_rx_s;
`endif

  assign w_par_en = (r_pm == PAR_EVEN) || (r_pm == PAR_ODD);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_s      <= '0;
      r_n      <= '0;
      r_b      <= '0;
      r_par    <= 1'b0;
      r_perr   <= 1'b0;
      r_pm     <= PAR_NONE;
      r_dout   <= '0;
      r_done   <= 1'b0;
      r_perr_o <= 1'b0;
      r_ferr   <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_s      <= w_s;
      r_n      <= w_n;
      r_b      <= w_b;
      r_par    <= w_par;
      r_perr   <= w_perr;
      r_pm     <= w_pm;
      r_dout   <= w_dout;
      r_done   <= w_done;
      r_perr_o <= w_perr_o;
      r_ferr   <= w_ferr;
    end
  end

  always_comb begin
    w_state  = r_state;
    w_s      = r_s;
    w_n      = r_n;
    w_b      = r_b;
    w_par    = r_par;
    w_perr   = r_perr;
    w_pm     = r_pm;
    w_dout   = r_dout;
    w_done   = 1'b0;
    w_perr_o = r_perr_o;
    w_ferr   = r_ferr;

    unique case (r_state)
      IDLE: begin
        if (!w_rx_s) begin
          w_state = START;
          w_s     = '0;
          w_pm    = bus.parity_mode;
        end
      end

      START: begin
        if (bus.s_tick) begin
          if (r_s == S_HALF) begin
            // A line that is high again at mid-start was only a glitch.
            if (!w_rx_s) begin
              w_state = DATA;
              w_s     = '0;
              w_n     = '0;
              w_par   = 1'b0;
              w_perr  = 1'b0;
            end else begin
              w_state = IDLE;
            end
          end else begin
            w_s = r_s + S_ONE;
          end
        end
      end

      DATA: begin
        if (bus.s_tick) begin
          if (r_s == S_BIT) begin
            w_s   = '0;
            w_b   = {w_bit, r_b[DBIT-1:1]};
            w_par = r_par ^ w_bit;
            if (r_n == N_LAST) w_state = w_par_en ? PARITY : STOP;
            else               w_n     = r_n + N_ONE;
          end else begin
            w_s = r_s + S_ONE;
          end
        end
      end

      PARITY: begin
        if (bus.s_tick) begin
          if (r_s == S_BIT) begin
            w_s     = '0;
            w_state = STOP;
            w_perr  = (r_pm == PAR_ODD) ? ~(r_par ^ w_bit) : (r_par ^ w_bit);
          end else begin
            w_s = r_s + S_ONE;
          end
        end
      end

      STOP: begin
        if (bus.s_tick) begin
          if (r_s == S_STOP) begin
            w_state  = IDLE;
            w_done   = 1'b1;
            w_dout   = r_b;
            w_perr_o = w_par_en ? r_perr : 1'b0;
            w_ferr   = ~w_bit;
          end else begin
            w_s = r_s + S_ONE;
          end
        end
      end

      default: w_state = IDLE;
    endcase
  end

  assign bus.rx_done_tick = r_done;
  assign bus.dout         = r_dout;
  assign bus.parity_err   = r_perr_o;
  assign bus.frame_err    = r_ferr;
  assign bus.rx_busy      = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param (DBIT=8, OVS=16, SB_TICK=16, tick every 4 clk).
// With UART_RX_MAJORITY_EN defined the final frame carries a short glitch in every data bit.
module tb_uart_rx_param;
  localparam int DBIT = 8;

`ifdef UART_RX_MAJORITY_EN
  localparam bit GLITCH = 1'b1;
`else
  localparam bit GLITCH = 1'b0;
`endif

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic sTick   = 1'b0;
  int   tickPhase  = 0;
  int   doneCnt    = 0;
  int   totalCount = 0;
  int   badCount   = 0;

  uart_rx_param_if #(.DBIT(DBIT)) bus ();

  uart_rx_param #(
    .DBIT    (DBIT),
    .OVS     (16),
    .SB_TICK (16)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  assign bus.s_tick = sTick;

  always #5 clk = ~clk;

  // One-clk tick strobe every fourth clock.
  always @(negedge clk) begin
    tickPhase = (tickPhase + 1) % 4;
    sTick     = (tickPhase == 0);
  end

  // The done strobe is one clock wide, so each pulse is counted exactly once here.
  always @(negedge clk) begin
    if (bus.rx_done_tick === 1'b1) doneCnt = doneCnt + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    totalCount = totalCount + 1;
    if (observed !== expected) begin
      badCount = badCount + 1;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Bit period is 64 clk; stop bit is driven for 48 clk then the line idles high.
  task automatic applyStimulus(input logic [7:0] data, input bit withPar, input bit parBit,
                               input bit stopBit, input bit glitch);
    bus.rx = 1'b0;
    waitClk(64);
    for (int i = 0; i < 8; i++) begin
      bus.rx = data[i];
      if (glitch) begin
        waitClk(28);
        bus.rx = ~data[i];
        waitClk(4);
        bus.rx = data[i];
        waitClk(32);
      end else begin
        waitClk(64);
      end
    end
    if (withPar) begin
      bus.rx = parBit;
      waitClk(64);
    end
    bus.rx = stopBit;
    waitClk(48);
    bus.rx = 1'b1;
    waitClk(96);
  endtask

  task automatic expectFrame(input string tag, input int base, input logic [7:0] data,
                             input logic pe, input logic fe);
    checkOutput({tag, ".cnt"},  32'(doneCnt),        32'(base + 1));
    checkOutput({tag, ".dout"}, 32'(bus.dout),       32'(data));
    checkOutput({tag, ".perr"}, 32'(bus.parity_err), 32'(pe));
    checkOutput({tag, ".ferr"}, 32'(bus.frame_err),  32'(fe));
  endtask

  initial begin
    int base;
    bus.rx          = 1'b1;
    bus.parity_mode = 2'b00;
    waitClk(4);
    checkOutput("rst.done", 32'(bus.rx_done_tick), 32'd0);
    checkOutput("rst.dout", 32'(bus.dout),         32'd0);
    checkOutput("rst.perr", 32'(bus.parity_err),   32'd0);
    checkOutput("rst.ferr", 32'(bus.frame_err),    32'd0);
    checkOutput("rst.busy", 32'(bus.rx_busy),      32'd0);
    reset_n = 1'b1;
    waitClk(64);

    $display("[TB] mode none, 0xA5");
    base = doneCnt;
    applyStimulus(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
    expectFrame("t1", base, 8'hA5, 1'b0, 1'b0);

    $display("[TB] even parity, 0x03");
    bus.parity_mode = 2'b01;
    base = doneCnt;
    applyStimulus(8'h03, 1'b1, 1'b0, 1'b1, 1'b0);
    expectFrame("t2a", base, 8'h03, 1'b0, 1'b0);
    base = doneCnt;
    applyStimulus(8'h03, 1'b1, 1'b1, 1'b1, 1'b0);
    expectFrame("t2b", base, 8'h03, 1'b1, 1'b0);

    $display("[TB] odd parity, 0x01");
    bus.parity_mode = 2'b10;
    base = doneCnt;
    applyStimulus(8'h01, 1'b1, 1'b0, 1'b1, 1'b0);
    expectFrame("t3a", base, 8'h01, 1'b0, 1'b0);
    base = doneCnt;
    applyStimulus(8'h01, 1'b1, 1'b1, 1'b1, 1'b0);
    expectFrame("t3b", base, 8'h01, 1'b1, 1'b0);

    $display("[TB] false start");
    bus.parity_mode = 2'b00;
    base = doneCnt;
    bus.rx = 1'b0;
    waitClk(10);
    checkOutput("t4.busyLow", 32'(bus.rx_busy), 32'd1);
    waitClk(10);
    bus.rx = 1'b1;
    waitClk(32);
    checkOutput("t4.busyIdle", 32'(bus.rx_busy), 32'd0);
    checkOutput("t4.cnt",      32'(doneCnt),     32'(base));
    checkOutput("t4.dout",     32'(bus.dout),    32'h01);
    checkOutput("t4.perr",     32'(bus.parity_err), 32'd1);

    $display("[TB] framing error then good frame");
    base = doneCnt;
    applyStimulus(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
    expectFrame("t5a", base, 8'h5A, 1'b0, 1'b1);
    base = doneCnt;
    applyStimulus(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0);
    expectFrame("t5b", base, 8'h3C, 1'b0, 1'b0);

    $display("[TB] reset mid-frame");
    base = doneCnt;
    bus.rx = 1'b0;
    waitClk(64);
    bus.rx = 1'b1;
    waitClk(64);
    bus.rx = 1'b0;
    waitClk(40);
    reset_n = 1'b0;
    waitClk(2);
    checkOutput("t6.busyRst", 32'(bus.rx_busy), 32'd0);
    checkOutput("t6.doutRst", 32'(bus.dout),    32'd0);
    bus.rx = 1'b1;
    waitClk(4);
    reset_n = 1'b1;
    waitClk(64);
    checkOutput("t6.cntRst", 32'(doneCnt), 32'(base));
    applyStimulus(8'h81, 1'b0, 1'b0, 1'b1, GLITCH);
    expectFrame("t6", base, 8'h81, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", totalCount, badCount);
    $finish;
  end

endmodule
